// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_pkg
// Purpose  : Shared TileLink-UL definitions for the load/store master and the
//            memory responder: A/D channel field positions, opcode constants
//            and the responder FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package tl_pkg;

    // A channel: opcode[54:52] param[51:49] size[48:46] source[45:44]
    //            address[43:34] data[33:2] valid[1] ready[0]
    localparam int A_OPCODE_LSB = 52;
    localparam int A_PARAM_LSB  = 49;
    localparam int A_SIZE_LSB   = 46;
    localparam int A_SOURCE_LSB = 44;
    localparam int A_ADDR_LSB   = 34;
    localparam int A_DATA_LSB   = 2;
    localparam int A_VALID_BIT  = 1;
    localparam int A_READY_BIT  = 0;

    // D channel: opcode[46:44] param[43:42] size[41:37] source[36:35]
    //            error[34] data[33:2] valid[1] ready[0]
    localparam int D_OPCODE_LSB = 44;
    localparam int D_PARAM_LSB  = 42;
    localparam int D_SIZE_LSB   = 37;
    localparam int D_SOURCE_LSB = 35;
    localparam int D_ERROR_BIT  = 34;
    localparam int D_DATA_LSB   = 2;
    localparam int D_VALID_BIT  = 1;
    localparam int D_READY_BIT  = 0;

    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } tl_state_e;

endpackage : tl_pkg
`default_nettype wire

// File: rtl/tl_resp_mem.sv
`default_nettype none
// ============================================================================
// Module   : tl_resp_mem
// Purpose  : Single-port synchronous RAM with write enable and registered
//            read data. Contents are never reset.
// Ports    : clk   - clock
//            en    - port enable (read or write this edge)
//            we    - write enable (qualified by en)
//            addr  - word address
//            wdata - write data
//            rdata - registered read data, holds until the next read
// Revision : 1.0 - initial release
// ============================================================================
module tl_resp_mem #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule : tl_resp_mem
`default_nettype wire

// File: rtl/tl_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_mem_responder
// Purpose  : TileLink-UL single-beat responder in front of the on-chip data
//            memory. Accepts one Get/PutFullData at a time from the A channel
//            and returns exactly one D channel response RESP_LATENCY-1 edges
//            after the capture edge (capture edge itself when latency is 1).
// Ports    : clk       - clock
//            reset     - asynchronous active-low reset
//            a_channel - 55-bit packed A channel (valid/ready in bits 1/0)
//            d_channel - 47-bit packed D channel (valid/ready in bits 1/0)
//            get_count, put_count, err_count, drop_count - saturating event
//            counters, present only when TL_RESPONDER_STATS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module tl_mem_responder
    import tl_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int RESP_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [54:0] a_channel,
    output logic [46:0] d_channel
`ifdef TL_RESPONDER_STATS_EN
    ,
    output logic [15:0] get_count,
    output logic [15:0] put_count,
    output logic [15:0] err_count,
    output logic [15:0] drop_count
`endif
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESP_LATENCY - 1);

    // ---------------- A channel decode ----------------
    logic [2:0]        w_a_opcode, w_a_size;
    logic [1:0]        w_a_source;
    logic [ADDR_W-1:0] w_a_addr;
    logic [DATA_W-1:0] w_a_data;
    logic              w_a_fire, w_capture, w_a_addr_ok, w_a_get, w_a_put;
    logic              unused_a_param;

    assign w_a_opcode  = a_channel[A_OPCODE_LSB +: 3];
    assign w_a_size    = a_channel[A_SIZE_LSB +: 3];
    assign w_a_source  = a_channel[A_SOURCE_LSB +: 2];
    assign w_a_addr    = a_channel[A_ADDR_LSB +: ADDR_W];
    assign w_a_data    = a_channel[A_DATA_LSB +: DATA_W];
    assign w_a_fire    = a_channel[A_VALID_BIT] & a_channel[A_READY_BIT];
    assign w_a_addr_ok = (32'(w_a_addr) < 32'(MEM_DEPTH));
    assign w_a_get     = (w_a_opcode == TL_GET);
    assign w_a_put     = (w_a_opcode == TL_PUT_FULL);
    assign unused_a_param = ^a_channel[A_PARAM_LSB +: 3];

    // ---------------- state ----------------
    tl_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        req_opcode_q, req_opcode_d, req_size_q, req_size_d;
    logic [1:0]        req_source_q, req_source_d;
    logic              req_ok_q, req_ok_d;
    logic              d_valid_q, d_valid_d, d_ready_q, d_ready_d;
    logic [2:0]        d_opcode_q, d_opcode_d;
    logic [4:0]        d_size_q, d_size_d;
    logic [1:0]        d_source_q, d_source_d;
    logic              d_error_q, d_error_d;
    logic              d_rdsel_q, d_rdsel_d;

    assign w_capture = (state_q == ST_IDLE) & w_a_fire;

    // Memory is accessed at the capture edge so a Put is complete before any
    // following request, and Get data sits in the RAM output register until
    // the response is issued. Only the address range check result needs to be
    // carried forward with the request.
    logic [DATA_W-1:0] w_ram_rdata;

    tl_resp_mem #(
        .ADDR_W (MEM_AW),
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .en    (w_capture & w_a_addr_ok & (w_a_get | w_a_put)),
        .we    (w_a_put),
        .addr  (w_a_addr[MEM_AW-1:0]),
        .wdata (w_a_data),
        .rdata (w_ram_rdata)
    );

    // Response source: the live A channel for a latency-1 response built at
    // the capture edge, otherwise the latched request.
    logic [2:0] w_sel_opcode, w_sel_size;
    logic [1:0] w_sel_source;
    logic       w_sel_ok, w_sel_get, w_sel_put, w_load_resp, w_resp_err;
    logic [CNT_W-1:0] w_cnt_dec;

    always_comb begin
        w_sel_opcode = req_opcode_q;
        w_sel_size   = req_size_q;
        w_sel_source = req_source_q;
        w_sel_ok     = req_ok_q;
        if (state_q == ST_IDLE) begin
            w_sel_opcode = w_a_opcode;
            w_sel_size   = w_a_size;
            w_sel_source = w_a_source;
            w_sel_ok     = w_a_addr_ok;
        end
    end

    assign w_sel_get  = (w_sel_opcode == TL_GET);
    assign w_sel_put  = (w_sel_opcode == TL_PUT_FULL);
    assign w_resp_err = ~(w_sel_ok & (w_sel_get | w_sel_put));
    assign w_cnt_dec  = cnt_q - CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_opcode_d = req_opcode_q;
        req_size_d   = req_size_q;
        req_source_d = req_source_q;
        req_ok_d     = req_ok_q;
        d_valid_d    = d_valid_q;
        d_ready_d    = d_ready_q;
        d_opcode_d   = d_opcode_q;
        d_size_d     = d_size_q;
        d_source_d   = d_source_q;
        d_error_d    = d_error_q;
        d_rdsel_d    = d_rdsel_q;
        w_load_resp  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_capture) begin
                    req_opcode_d = w_a_opcode;
                    req_size_d   = w_a_size;
                    req_source_d = w_a_source;
                    req_ok_d     = w_a_addr_ok;
                    cnt_d        = CNT_LOAD;
                    d_ready_d    = 1'b0;
                    if (RESP_LATENCY > 1) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d     = ST_RESP;
                        w_load_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = w_cnt_dec;
                if (w_cnt_dec == '0) begin
                    state_d     = ST_RESP;
                    w_load_resp = 1'b1;
                end
            end
            ST_RESP: begin
                // Single-cycle pulse; fields cleared so an idle D channel
                // reads back as ready-only.
                state_d    = ST_IDLE;
                d_valid_d  = 1'b0;
                d_ready_d  = 1'b1;
                d_opcode_d = '0;
                d_size_d   = '0;
                d_source_d = '0;
                d_error_d  = 1'b0;
                d_rdsel_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_load_resp) begin
            d_valid_d  = 1'b1;
            d_opcode_d = w_sel_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
            d_size_d   = {2'b00, w_sel_size};
            d_source_d = w_sel_source;
            d_error_d  = w_resp_err;
            d_rdsel_d  = w_sel_get & w_sel_ok;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_opcode_q <= '0;
            req_size_q   <= '0;
            req_source_q <= '0;
            req_ok_q     <= 1'b0;
            d_valid_q    <= 1'b0;
            d_ready_q    <= 1'b1;
            d_opcode_q   <= '0;
            d_size_q     <= '0;
            d_source_q   <= '0;
            d_error_q    <= 1'b0;
            d_rdsel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_opcode_q <= req_opcode_d;
            req_size_q   <= req_size_d;
            req_source_q <= req_source_d;
            req_ok_q     <= req_ok_d;
            d_valid_q    <= d_valid_d;
            d_ready_q    <= d_ready_d;
            d_opcode_q   <= d_opcode_d;
            d_size_q     <= d_size_d;
            d_source_q   <= d_source_d;
            d_error_q    <= d_error_d;
            d_rdsel_q    <= d_rdsel_d;
        end
    end

    assign d_channel[D_OPCODE_LSB +: 3]      = d_opcode_q;
    assign d_channel[D_PARAM_LSB +: 2]       = 2'b00;
    assign d_channel[D_SIZE_LSB +: 5]        = d_size_q;
    assign d_channel[D_SOURCE_LSB +: 2]      = d_source_q;
    assign d_channel[D_ERROR_BIT]            = d_error_q;
    assign d_channel[D_DATA_LSB +: DATA_W]   = d_rdsel_q ? w_ram_rdata : '0;
    assign d_channel[D_VALID_BIT]            = d_valid_q;
    assign d_channel[D_READY_BIT]            = d_ready_q;

`ifdef TL_RESPONDER_STATS_EN
    logic [15:0] get_count_q, get_count_d, put_count_q, put_count_d;
    logic [15:0] err_count_q, err_count_d, drop_count_q, drop_count_d;
    logic        w_drop;

    // A handshake outside IDLE is lost; that is what drop_count records.
    assign w_drop = w_a_fire & (state_q != ST_IDLE);

    always_comb begin
        get_count_d  = get_count_q;
        put_count_d  = put_count_q;
        err_count_d  = err_count_q;
        drop_count_d = drop_count_q;
        if (w_capture && w_a_get && get_count_q != 16'hFFFF) begin
            get_count_d = get_count_q + 16'd1;
        end
        if (w_capture && w_a_put && put_count_q != 16'hFFFF) begin
            put_count_d = put_count_q + 16'd1;
        end
        if (w_load_resp && w_resp_err && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
        if (w_drop && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            get_count_q  <= '0;
            put_count_q  <= '0;
            err_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            get_count_q  <= get_count_d;
            put_count_q  <= put_count_d;
            err_count_q  <= err_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign get_count  = get_count_q;
    assign put_count  = put_count_q;
    assign err_count  = err_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule : tl_mem_responder
`default_nettype wire

// File: tb/tb_tl_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_mem_responder
// Purpose  : Self-checking bench for tl_mem_responder. Three instances with
//            RESP_LATENCY 1, 2 and 3 (MEM_DEPTH 512) share one A channel and
//            are compared against a word-array memory model. Drives
//            TL_RESPONDER_STATS_EN-dependent ports when that macro is set.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tl_mem_responder;

    localparam int DEPTH = 512;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [54:0]      a_ch;
    logic [2:0][46:0] d_ch;
`ifdef TL_RESPONDER_STATS_EN
    logic [2:0][15:0] get_cnt, put_cnt, err_cnt, drop_cnt;
`endif

    always #5 clk = ~clk;

    tl_mem_responder #(.ADDR_W(10), .DATA_W(32), .MEM_DEPTH(DEPTH), .RESP_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(rst_n), .a_channel(a_ch), .d_channel(d_ch[0])
`ifdef TL_RESPONDER_STATS_EN
        , .get_count(get_cnt[0]), .put_count(put_cnt[0]), .err_count(err_cnt[0]), .drop_count(drop_cnt[0])
`endif
    );
    tl_mem_responder #(.ADDR_W(10), .DATA_W(32), .MEM_DEPTH(DEPTH), .RESP_LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(rst_n), .a_channel(a_ch), .d_channel(d_ch[1])
`ifdef TL_RESPONDER_STATS_EN
        , .get_count(get_cnt[1]), .put_count(put_cnt[1]), .err_count(err_cnt[1]), .drop_count(drop_cnt[1])
`endif
    );
    tl_mem_responder #(.ADDR_W(10), .DATA_W(32), .MEM_DEPTH(DEPTH), .RESP_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(rst_n), .a_channel(a_ch), .d_channel(d_ch[2])
`ifdef TL_RESPONDER_STATS_EN
        , .get_count(get_cnt[2]), .put_count(put_cnt[2]), .err_count(err_cnt[2]), .drop_count(drop_cnt[2])
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [DEPTH];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One request, then five samples on falling edges. A latency-L instance
    // must show valid only on sample L-1 and ready again from sample L on.
    task automatic send(input logic [2:0] op, input logic [9:0] addr, input logic [31:0] data,
                        input logic [1:0] src, input logic [2:0] size, input bit drop_next);
        bit          is_get, is_put, ok, ev;
        logic [2:0]  exp_op;
        logic        exp_err;
        logic [31:0] exp_data;
        is_get   = (op == 3'd4);
        is_put   = (op == 3'd0);
        ok       = (int'(addr) < DEPTH);
        exp_err  = !((is_get || is_put) && ok);
        exp_op   = is_get ? 3'd1 : 3'd0;
        exp_data = (is_get && ok) ? ref_mem[addr] : 32'd0;
        if (is_put && ok) ref_mem[addr] = data;

        @(negedge clk);
        a_ch = {op, 3'($urandom), size, src, addr, data, 2'b11};
        @(posedge clk);
        #1;
        // Optional back-to-back Put that every instance must discard.
        a_ch = drop_next ? {3'd0, 3'd0, 3'd2, 2'd3, addr, 32'hBAD0_0000 | 32'(addr), 2'b11} : '0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                ev = (s == i);
                check_eq($sformatf("L%0d s%0d d_valid", i + 1, s), 64'(d_ch[i][1]), 64'(ev));
                check_eq($sformatf("L%0d s%0d d_ready", i + 1, s), 64'(d_ch[i][0]), 64'(s >= i + 1));
                if (ev) begin
                    check_eq($sformatf("L%0d op%0d a%0h d_opcode", i + 1, op, addr), 64'(d_ch[i][46:44]), 64'(exp_op));
                    check_eq($sformatf("L%0d d_param", i + 1), 64'(d_ch[i][43:42]), 64'd0);
                    check_eq($sformatf("L%0d d_size", i + 1), 64'(d_ch[i][41:37]), 64'(size));
                    check_eq($sformatf("L%0d d_source", i + 1), 64'(d_ch[i][36:35]), 64'(src));
                    check_eq($sformatf("L%0d op%0d a%0h d_error", i + 1, op, addr), 64'(d_ch[i][34]), 64'(exp_err));
                    check_eq($sformatf("L%0d op%0d a%0h d_data", i + 1, op, addr), 64'(d_ch[i][33:2]), 64'(exp_data));
                end
            end
            if (s == 1) a_ch = '0;
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [9:0]  addr;
        int          r;

        a_ch  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_eq($sformatf("L%0d reset d_channel", i + 1), 64'(d_ch[i]), 64'h1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_eq($sformatf("L%0d idle d_channel", i + 1), 64'(d_ch[i]), 64'h1);
        end

        // Give every address the bench reads a known value.
        for (int a = 0; a < 16; a++)       send(3'd0, 10'(a), $urandom, 2'd0, 3'd2, 1'b0);
        for (int a = 496; a < DEPTH; a++)  send(3'd0, 10'(a), $urandom, 2'd0, 3'd2, 1'b0);

        // Put then Get read-after-write.
        send(3'd0, 10'h005, 32'hDEADBEEF, 2'd1, 3'd2, 1'b0);
        send(3'd4, 10'h005, 32'h0, 2'd1, 3'd2, 1'b0);

        // Out-of-range Get, then in-range Get unaffected.
        send(3'd4, 10'h3FF, 32'h0, 2'd2, 3'd2, 1'b0);
        send(3'd4, 10'h000, 32'h0, 2'd0, 3'd2, 1'b0);

        // Unsupported opcode must not write.
        send(3'd2, 10'h007, 32'h12345678, 2'd3, 3'd1, 1'b0);
        send(3'd4, 10'h007, 32'h0, 2'd3, 3'd2, 1'b0);

        // Busy drop: second request one cycle after capture is discarded.
        send(3'd4, 10'h009, 32'h0, 2'd1, 3'd2, 1'b1);
`ifdef TL_RESPONDER_STATS_EN
        for (int i = 0; i < 3; i++) check_eq($sformatf("L%0d drop_count", i + 1), 64'(drop_cnt[i]), 64'd1);
`endif
        send(3'd4, 10'h009, 32'h0, 2'd1, 3'd2, 1'b0);

        // a_valid without a_ready is ignored.
        @(negedge clk);
        a_ch = {3'd0, 3'd0, 3'd2, 2'd0, 10'h003, 32'hFFFF0000, 2'b10};
        repeat (4) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_eq($sformatf("L%0d no-ready d_valid", i + 1), 64'(d_ch[i][1]), 64'd0);
        end
        a_ch = '0;
        send(3'd4, 10'h003, 32'h0, 2'd2, 3'd2, 1'b0);

        // Reset mid-request drops the response.
        @(negedge clk);
        a_ch = {3'd4, 3'd0, 3'd2, 2'd1, 10'h001, 32'h0, 2'b11};
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        a_ch  = '0;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_eq($sformatf("L%0d mid-reset d_channel", i + 1), 64'(d_ch[i]), 64'h1);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_eq($sformatf("L%0d post-reset d_channel", i + 1), 64'(d_ch[i]), 64'h1);
        end
        send(3'd4, 10'h001, 32'h0, 2'd1, 3'd2, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      op = 3'd4;
            else if (r < 8) op = 3'd0;
            else            op = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 3)) : 3'($urandom_range(5, 7));
            r = $urandom_range(0, 9);
            if (r < 4)      addr = 10'($urandom_range(0, 15));
            else if (r < 8) addr = 10'($urandom_range(496, 511));
            else            addr = 10'($urandom_range(512, 1023));
            send(op, addr, $urandom, 2'($urandom), 3'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tl_mem_responder
`default_nettype wire
